issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard_pkg.sv | 24 ++
 rtl/issue_scoreboard_regs.sv | 70 +++++++
 rtl/issue_scoreboard.sv | 115 +++++++++++
 tb/tb_issue_scoreboard.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue scoreboard: FSM states,
// register-file constants and the staged issue bundle.
package issue_scoreboard_pkg;

   localparam int REG_IDX_W = 5;
   localparam int NREG      = 32;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      HELD    = 2'd1,
      BR_WAIT = 2'd2
   } state_e;

   typedef struct packed {
      logic                 rs1_valid;
      logic                 rs2_valid;
      logic [REG_IDX_W-1:0] rs1;
      logic [REG_IDX_W-1:0] rs2;
      logic [REG_IDX_W-1:0] rd;
      logic                 regwrite;
      logic                 ctrl;
   } iss_bundle_t;

endpackage

// File: rtl/issue_scoreboard_regs.sv
// Pending-write bit vector and in-flight writer count.
// x0 is never marked busy; a clear of x0 is a no-op.
module scoreboard_regs
   import issue_scoreboard_pkg::*;
#(
   parameter int MAX_OUT = 8,
   parameter int CW      = $clog2(MAX_OUT) + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 set_i,
   input  logic [REG_IDX_W-1:0] set_rd_i,
   input  logic                 clr_i,
   input  logic [REG_IDX_W-1:0] clr_rd_i,
   output logic [NREG-1:0]      busy_vec_o,
   output logic [CW-1:0]        out_cnt_o
);

   logic [NREG-1:0] busy_q, busy_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            set_eff, clr_eff;
   logic            inc, dec;

   assign set_eff = set_i & (set_rd_i != '0);
   assign clr_eff = clr_i & (clr_rd_i != '0);

   // Saturating guards keep the counter from wrapping on illegal input.
   assign inc = set_eff & (cnt_q != CW'(MAX_OUT));
   assign dec = clr_eff & (cnt_q != '0);

   always_comb begin
      busy_d = busy_q;
      if (set_eff) busy_d[set_rd_i] = 1'b1;
      if (clr_eff) busy_d[clr_rd_i] = 1'b0;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d = cnt_q;
      unique case ({inc, dec})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_vec_o = busy_q;
   assign out_cnt_o  = cnt_q;

   a_no_same_reg: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      !(set_eff && clr_eff && (set_rd_i == clr_rd_i)))
      else $error("set and clear of same register");

   a_no_underflow: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      !(clr_eff && (cnt_q == '0)))
      else $error("writeback with nothing outstanding");

endmodule

// File: rtl/issue_scoreboard.sv
// One-entry issue stage with RAW/WAW/capacity interlock
// and a branch shadow that blocks the frontend until resolve.
module issue_scoreboard
   import issue_scoreboard_pkg::*;
#(
   parameter int MAX_OUT = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ifq_valid,
   output logic                 ifq_ready,
   input  logic                 dec_rs1_valid,
   input  logic                 dec_rs2_valid,
   input  logic [REG_IDX_W-1:0] dec_rs1,
   input  logic [REG_IDX_W-1:0] dec_rs2,
   input  logic [REG_IDX_W-1:0] dec_rd,
   input  logic                 dec_regwrite,
   input  logic                 dec_br,
   input  logic                 dec_j,
   output logic                 iss_valid,
   input  logic                 iss_ready,
   output logic [REG_IDX_W-1:0] iss_rs1,
   output logic [REG_IDX_W-1:0] iss_rs2,
   output logic [REG_IDX_W-1:0] iss_rd,
   output logic                 iss_regwrite,
   output logic                 iss_ctrl,
   input  logic                 wb_valid,
   input  logic [REG_IDX_W-1:0] wb_rd,
   input  logic                 br_resolve,
   output logic [NREG-1:0]      busy_vec
);

   localparam int CW = $clog2(MAX_OUT) + 1;

   state_e          state_q;
   iss_bundle_t     stage_q;
   iss_bundle_t     dec_b;
   logic [NREG-1:0] busy;
   logic [CW-1:0]   out_cnt;
   logic            hazard;
   logic            issue;

   assign dec_b.rs1_valid = dec_rs1_valid;
   assign dec_b.rs2_valid = dec_rs2_valid;
   assign dec_b.rs1       = dec_rs1;
   assign dec_b.rs2       = dec_rs2;
   assign dec_b.rd        = dec_rd;
   assign dec_b.regwrite  = dec_regwrite;
   assign dec_b.ctrl      = dec_br | dec_j;

   // Registered busy/count only: a writeback unblocks the next cycle.
   assign hazard =
        (stage_q.rs1_valid & busy[stage_q.rs1])
      | (stage_q.rs2_valid & busy[stage_q.rs2])
      | (stage_q.regwrite  & busy[stage_q.rd])
      | (stage_q.regwrite  & (out_cnt == CW'(MAX_OUT)));

   assign iss_valid = (state_q == HELD) & ~hazard;
   assign issue     = iss_valid & iss_ready;
   assign ifq_ready = (state_q == EMPTY)
                    | (issue & ~stage_q.ctrl);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         stage_q <= '0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (ifq_valid) begin
                  stage_q <= dec_b;
                  state_q <= HELD;
               end
            end
            HELD: begin
               if (issue) begin
                  if (stage_q.ctrl) begin
                     state_q <= BR_WAIT;
                  end else if (ifq_valid) begin
                     stage_q <= dec_b;
                  end else begin
                     state_q <= EMPTY;
                  end
               end
            end
            BR_WAIT: begin
               if (br_resolve) state_q <= EMPTY;
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

   scoreboard_regs #(
      .MAX_OUT (MAX_OUT),
      .CW      (CW)
   ) u_regs (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .set_i      (issue & stage_q.regwrite),
      .set_rd_i   (stage_q.rd),
      .clr_i      (wb_valid),
      .clr_rd_i   (wb_rd),
      .busy_vec_o (busy),
      .out_cnt_o  (out_cnt)
   );

   assign busy_vec     = busy;
   assign iss_rs1      = stage_q.rs1;
   assign iss_rs2      = stage_q.rs2;
   assign iss_rd       = stage_q.rd;
   assign iss_regwrite = stage_q.regwrite;
   assign iss_ctrl     = stage_q.ctrl;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed scenarios plus randomized traffic checked
// against a queue-based model of in-flight writers.
module tb_issue_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ifq_valid, ifq_ready;
   logic        dec_rs1_valid, dec_rs2_valid;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic        dec_regwrite, dec_br, dec_j;
   logic        iss_valid, iss_ready;
   logic [4:0]  iss_rs1, iss_rs2, iss_rd;
   logic        iss_regwrite, iss_ctrl;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        br_resolve;
   logic [31:0] busy_vec;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   issue_scoreboard #(.MAX_OUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifq_valid(ifq_valid), .ifq_ready(ifq_ready),
      .dec_rs1_valid(dec_rs1_valid),
      .dec_rs2_valid(dec_rs2_valid),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_rd(dec_rd), .dec_regwrite(dec_regwrite),
      .dec_br(dec_br), .dec_j(dec_j),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
      .iss_rd(iss_rd), .iss_regwrite(iss_regwrite),
      .iss_ctrl(iss_ctrl),
      .wb_valid(wb_valid), .wb_rd(wb_rd),
      .br_resolve(br_resolve), .busy_vec(busy_vec)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      ifq_valid = 0; dec_rs1_valid = 0; dec_rs2_valid = 0;
      dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
      dec_regwrite = 0; dec_br = 0; dec_j = 0;
      iss_ready = 0; wb_valid = 0; wb_rd = 0;
      br_resolve = 0;
   endtask

   task automatic bundle(input int rd, input int rw,
                         input int r1v, input int r1,
                         input int br);
      idle();
      ifq_valid = 1;
      dec_rd = 5'(rd); dec_regwrite = rw[0];
      dec_rs1_valid = r1v[0]; dec_rs1 = 5'(r1);
      dec_br = br[0];
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      cyc(); cyc();
      rst_n = 1;
      cyc();
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1;
      cyc();
      #2 rst_n = 0;
      settle();
      total_cnt++;
      if ({iss_valid, ifq_ready} !== 2'b01)
         $display("FAIL reset_hs got %b exp 01",
                  {iss_valid, ifq_ready});
      else pass_cnt++;
      total_cnt++;
      if (busy_vec !== 32'h0)
         $display("FAIL reset_busy got %h exp 0", busy_vec);
      else pass_cnt++;
      total_cnt++;
      if ({iss_rs1, iss_rs2, iss_rd, iss_regwrite, iss_ctrl} !== '0)
         $display("FAIL reset_iss got %h exp 0",
            {iss_rs1, iss_rs2, iss_rd, iss_regwrite, iss_ctrl});
      else pass_cnt++;
      cyc();
      rst_n = 1;
      cyc();
   endtask

   task automatic test_raw_stall();
      bundle(5, 1, 0, 0, 0);
      settle();
      total_cnt++;
      if (ifq_ready !== 1'b1)
         $display("FAIL raw_accept got %b exp 1", ifq_ready);
      else pass_cnt++;
      cyc();
      bundle(0, 0, 1, 5, 0);
      iss_ready = 1;
      settle();
      total_cnt++;
      if (iss_valid !== 1'b1 || iss_rd !== 5'd5)
         $display("FAIL raw_first_issue got v=%b rd=%0d exp v=1 rd=5",
                  iss_valid, iss_rd);
      else pass_cnt++;
      cyc();
      ifq_valid = 0;
      for (int i = 0; i < 3; i++) begin
         settle();
         total_cnt++;
         if (iss_valid !== 1'b0 || busy_vec !== 32'h20)
            $display("FAIL raw_stall got v=%b busy=%h exp v=0 busy=20",
                     iss_valid, busy_vec);
         else pass_cnt++;
         cyc();
      end
      wb_valid = 1; wb_rd = 5;
      settle();
      total_cnt++;
      if (iss_valid !== 1'b0)
         $display("FAIL raw_no_bypass got %b exp 0", iss_valid);
      else pass_cnt++;
      cyc();
      wb_valid = 0;
      settle();
      total_cnt++;
      if (iss_valid !== 1'b1 || busy_vec !== 32'h0)
         $display("FAIL raw_release got v=%b busy=%h exp v=1 busy=0",
                  iss_valid, busy_vec);
      else pass_cnt++;
      cyc();
      idle();
      settle();
      total_cnt++;
      if (ifq_ready !== 1'b1 || iss_valid !== 1'b0)
         $display("FAIL raw_empty got r=%b v=%b exp r=1 v=0",
                  ifq_ready, iss_valid);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k <= 3; k++) begin
         if (k < 3) bundle(k + 1, 1, 0, 0, 0);
         else idle();
         iss_ready = 1;
         settle();
         if (k > 0) begin
            total_cnt++;
            if (iss_valid !== 1'b1 || iss_rd !== 5'(k)
                || (k < 3 && ifq_ready !== 1'b1))
               $display("FAIL b2b_issue%0d got v=%b rd=%0d r=%b exp v=1 rd=%0d",
                        k, iss_valid, iss_rd, ifq_ready, k);
            else pass_cnt++;
         end
         cyc();
      end
      idle();
      settle();
      total_cnt++;
      if (busy_vec !== 32'h0000000E)
         $display("FAIL b2b_busy got %h exp 0000000e", busy_vec);
      else pass_cnt++;
      for (int r = 1; r <= 3; r++) begin
         wb_valid = 1; wb_rd = 5'(r);
         cyc();
      end
      idle();
      settle();
      total_cnt++;
      if (busy_vec !== 32'h0)
         $display("FAIL b2b_drain got %h exp 0", busy_vec);
      else pass_cnt++;
   endtask

   task automatic test_branch();
      br_resolve = 1;
      settle();
      cyc();
      br_resolve = 0;
      settle();
      total_cnt++;
      if (ifq_ready !== 1'b1 || iss_valid !== 1'b0)
         $display("FAIL br_ignored got r=%b v=%b exp r=1 v=0",
                  ifq_ready, iss_valid);
      else pass_cnt++;
      bundle(0, 0, 0, 0, 1);
      cyc();
      bundle(7, 1, 0, 0, 0);
      iss_ready = 1;
      settle();
      total_cnt++;
      if (iss_valid !== 1'b1 || iss_ctrl !== 1'b1 || ifq_ready !== 1'b0)
         $display("FAIL br_issue got v=%b c=%b r=%b exp v=1 c=1 r=0",
                  iss_valid, iss_ctrl, ifq_ready);
      else pass_cnt++;
      cyc();
      for (int i = 0; i < 3; i++) begin
         settle();
         total_cnt++;
         if (ifq_ready !== 1'b0 || iss_valid !== 1'b0)
            $display("FAIL br_wait got r=%b v=%b exp r=0 v=0",
                     ifq_ready, iss_valid);
         else pass_cnt++;
         cyc();
      end
      br_resolve = 1;
      cyc();
      idle();
      settle();
      total_cnt++;
      if (ifq_ready !== 1'b1)
         $display("FAIL br_resolve got %b exp 1", ifq_ready);
      else pass_cnt++;
   endtask

   task automatic test_x0();
      bundle(0, 0, 0, 0, 0);
      cyc();
      idle();
      iss_ready = 1;
      wb_valid = 1; wb_rd = 0;
      cyc();
      idle();
      settle();
      total_cnt++;
      if (busy_vec !== 32'h0 || ifq_ready !== 1'b1)
         $display("FAIL x0 got busy=%h r=%b exp busy=0 r=1",
                  busy_vec, ifq_ready);
      else pass_cnt++;
   endtask

   task automatic test_capacity();
      for (int k = 1; k <= 9; k++) begin
         bundle(k, 1, 0, 0, 0);
         iss_ready = 1;
         cyc();
      end
      idle();
      iss_ready = 1;
      for (int i = 0; i < 2; i++) begin
         settle();
         total_cnt++;
         if (iss_valid !== 1'b0 || busy_vec !== 32'h1FE)
            $display("FAIL cap_full got v=%b busy=%h exp v=0 busy=1fe",
                     iss_valid, busy_vec);
         else pass_cnt++;
         cyc();
      end
      wb_valid = 1; wb_rd = 1;
      settle();
      total_cnt++;
      if (iss_valid !== 1'b0)
         $display("FAIL cap_wb_cycle got %b exp 0", iss_valid);
      else pass_cnt++;
      cyc();
      wb_valid = 0;
      settle();
      total_cnt++;
      if (iss_valid !== 1'b1 || iss_rd !== 5'd9)
         $display("FAIL cap_ninth got v=%b rd=%0d exp v=1 rd=9",
                  iss_valid, iss_rd);
      else pass_cnt++;
      cyc();
      do_reset();
   endtask

   task automatic test_async_reset();
      bundle(5, 1, 0, 0, 0);
      cyc();
      bundle(6, 1, 0, 0, 0);
      iss_ready = 1;
      cyc();
      idle();
      settle();
      total_cnt++;
      if (iss_valid !== 1'b1 || busy_vec !== 32'h20)
         $display("FAIL arst_pre got v=%b busy=%h exp v=1 busy=20",
                  iss_valid, busy_vec);
      else pass_cnt++;
      #1 rst_n = 0;
      #1;
      total_cnt++;
      if (iss_valid !== 1'b0 || busy_vec !== 32'h0
          || ifq_ready !== 1'b1 || iss_rd !== 5'd0)
         $display("FAIL arst got v=%b busy=%h r=%b rd=%0d exp 0/0/1/0",
                  iss_valid, busy_vec, ifq_ready, iss_rd);
      else pass_cnt++;
      #1 rst_n = 1;
      cyc();
      bundle(9, 1, 0, 0, 0);
      settle();
      total_cnt++;
      if (ifq_ready !== 1'b1)
         $display("FAIL arst_accept got %b exp 1", ifq_ready);
      else pass_cnt++;
      cyc();
      idle();
      settle();
      total_cnt++;
      if (iss_valid !== 1'b1 || iss_rd !== 5'd9)
         $display("FAIL arst_first got v=%b rd=%0d exp v=1 rd=9",
                  iss_valid, iss_rd);
      else pass_cnt++;
      do_reset();
   endtask

   task automatic test_random();
      int inflight[$];
      bit staged, bwait, bw_prev, st_rw, st_ctrl, st_r1v, st_r2v;
      int st_rd, st_r1, st_r2;
      bit [31:0] exp_busy;
      bit haz, exp_v, exp_r, iss;
      int idx;
      staged = 0; bwait = 0;
      st_rw = 0; st_ctrl = 0; st_r1v = 0; st_r2v = 0;
      st_rd = 0; st_r1 = 0; st_r2 = 0;
      for (int c = 0; c < 600; c++) begin
         idle();
         ifq_valid = ($urandom % 3) != 0;
         dec_rd = 5'($urandom_range(0, 12));
         dec_regwrite = (dec_rd != 0) && ($urandom % 4 != 0);
         dec_rs1_valid = $urandom % 2;
         dec_rs2_valid = $urandom % 2;
         dec_rs1 = 5'($urandom_range(0, 12));
         dec_rs2 = 5'($urandom_range(0, 12));
         dec_br = ($urandom % 10) == 0;
         dec_j = ($urandom % 14) == 0;
         iss_ready = ($urandom % 4) != 0;
         if (inflight.size() > 0 && ($urandom % 3) == 0) begin
            idx = $urandom_range(0, inflight.size() - 1);
            wb_valid = 1; wb_rd = 5'(inflight[idx]);
         end else if (($urandom % 12) == 0) begin
            wb_valid = 1; wb_rd = 0;
         end
         br_resolve = bwait ? (($urandom % 3) == 0)
                            : (($urandom % 10) == 0);
         exp_busy = 0;
         foreach (inflight[i]) exp_busy[inflight[i]] = 1'b1;
         haz = (st_r1v && exp_busy[st_r1])
            || (st_r2v && exp_busy[st_r2])
            || (st_rw && exp_busy[st_rd])
            || (st_rw && inflight.size() == 8);
         exp_v = staged && !haz;
         iss = exp_v && iss_ready;
         exp_r = (!staged && !bwait) || (iss && !st_ctrl);
         settle();
         total_cnt++;
         if (iss_valid !== exp_v || ifq_ready !== exp_r)
            $display("FAIL rnd_hs c=%0d got v=%b r=%b exp v=%b r=%b",
                     c, iss_valid, ifq_ready, exp_v, exp_r);
         else pass_cnt++;
         total_cnt++;
         if (busy_vec !== exp_busy)
            $display("FAIL rnd_busy c=%0d got %h exp %h",
                     c, busy_vec, exp_busy);
         else pass_cnt++;
         if (exp_v) begin
            total_cnt++;
            if (iss_rd !== 5'(st_rd) || iss_ctrl !== st_ctrl
                || iss_regwrite !== st_rw)
               $display("FAIL rnd_data c=%0d got rd=%0d c=%b w=%b exp rd=%0d c=%b w=%b",
                        c, iss_rd, iss_ctrl, iss_regwrite,
                        st_rd, st_ctrl, st_rw);
            else pass_cnt++;
         end
         bw_prev = bwait;
         if (wb_valid && wb_rd != 0) begin
            foreach (inflight[i])
               if (inflight[i] == int'(wb_rd)) idx = i;
            inflight.delete(idx);
         end
         if (bw_prev && br_resolve) bwait = 0;
         if (iss) begin
            if (st_rw) inflight.push_back(st_rd);
            if (st_ctrl) bwait = 1;
            staged = 0;
         end
         if (exp_r && ifq_valid) begin
            staged = 1;
            st_rd = int'(dec_rd); st_rw = dec_regwrite;
            st_r1 = int'(dec_rs1); st_r1v = dec_rs1_valid;
            st_r2 = int'(dec_rs2); st_r2v = dec_rs2_valid;
            st_ctrl = dec_br | dec_j;
         end
         cyc();
      end
      do_reset();
   endtask

   initial begin
      idle();
      rst_n = 0;
      test_reset();
      test_raw_stall();
      test_back_to_back();
      test_branch();
      test_x0();
      test_capacity();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
